// File: rtl/inst_buffer.sv
// inst_buffer: fetch-to-decode instruction FIFO with flush; optional INST_BUFFER_BYPASS_EN adds an empty-buffer bypass path
module inst_buffer #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  T     in_instr,
  input  T     in_pc,
  output logic in_ready,
  output logic out_valid,
  output T     out_instr,
  output T     out_pc,
  input  logic out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem_instr [DEPTH];
  T mem_pc [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic bypass, enq, deq;
`ifdef INST_BUFFER_BYPASS_EN
  assign bypass = count == '0 && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = (count != '0 && !flush) || bypass;
  assign out_instr = !out_valid ? '0 : bypass ? in_instr : mem_instr[rd_ptr];
  assign out_pc    = !out_valid ? '0 : bypass ? in_pc : mem_pc[rd_ptr];
  // a bypassed instruction consumed by decode never touches the array
  assign enq = in_valid && in_ready && !flush && !(bypass && out_ready);
  assign deq = out_valid && out_ready && !bypass;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count + CW'(enq) - CW'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end
endmodule
